// File: rtl/key_debounce.sv
// Pushbutton debounce and switch synchroniser for the DE10-Lite SoC PIO inputs.
// Optional accepted-press counter: define KEY_DEBOUNCE_PRESS_COUNT_EN.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1,
    parameter int unsigned SW_W            = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            key_n_in,
    input  logic [SW_W-1:0] sw_in,
    output logic            key_n_out,
    output logic            press_pulse,
    output logic            release_pulse,
`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
    output logic [7:0]      press_count,
`endif
    output logic [SW_W-1:0] sw_out
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressPend,
        StPressed,
        StReleasePend
    } state_e;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              key_meta;
    logic              key_sync;
    logic [SW_W-1:0]   sw_meta;
    logic              press_accept;
    logic              release_accept;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            sw_meta  <= '0;
            sw_out   <= '0;
        end else begin
            key_meta <= key_n_in;
            key_sync <= key_meta;
            sw_meta  <= sw_in;
            sw_out   <= sw_meta;
        end
    end

    // A pending level is accepted once it has been stable for DEBOUNCE_CYCLES edges.
    assign press_accept   = (state == StPressPend) && !key_sync && (cnt == CntMax);
    assign release_accept = (state == StReleasePend) && key_sync && (cnt == CntMax);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= StReleased;
            cnt           <= '0;
            key_n_out     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                StReleased: begin
                    cnt <= '0;
                    if (!key_sync) begin
                        state <= StPressPend;
                    end
                end
                StPressPend: begin
                    if (key_sync) begin
                        state <= StReleased;
                        cnt   <= '0;
                    end else if (press_accept) begin
                        state       <= StPressed;
                        cnt         <= '0;
                        key_n_out   <= 1'b0;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StPressed: begin
                    cnt <= '0;
                    if (key_sync) begin
                        state <= StReleasePend;
                    end
                end
                StReleasePend: begin
                    if (!key_sync) begin
                        state <= StPressed;
                        cnt   <= '0;
                    end else if (release_accept) begin
                        state         <= StReleased;
                        cnt           <= '0;
                        key_n_out     <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= StReleased;
                    cnt       <= '0;
                    key_n_out <= 1'b1;
                end
            endcase
        end
    end

`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            press_count <= 8'd0;
        end else if (press_accept) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert (!(press_pulse && release_pulse));
            assert (cnt <= CntMax);
        end
    end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce (DEBOUNCE_CYCLES=4 and =1 instances).
module tb_key_debounce;

    logic       clk;
    logic       rst;
    logic       key_n;
    logic       key1_n;
    logic [7:0] sw_in;

    logic       key_n_out, press_pulse, release_pulse;
    logic [7:0] sw_out;
    logic       key1_n_out, press1_pulse, release1_pulse;
    logic [7:0] sw1_out;
`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
    logic [7:0] press_count;
    logic [7:0] press1_count;
`endif

    int compared;
    int mismatched;

    key_debounce #(.DEBOUNCE_CYCLES(4), .SW_W(8)) dut (
        .Clk          (clk),
        .Reset        (rst),
        .key_n_in     (key_n),
        .sw_in        (sw_in),
        .key_n_out    (key_n_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
        .press_count  (press_count),
`endif
        .sw_out       (sw_out)
    );

    key_debounce #(.DEBOUNCE_CYCLES(1), .SW_W(8)) dut1 (
        .Clk          (clk),
        .Reset        (rst),
        .key_n_in     (key1_n),
        .sw_in        (sw_in),
        .key_n_out    (key1_n_out),
        .press_pulse  (press1_pulse),
        .release_pulse(release1_pulse),
`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
        .press_count  (press1_count),
`endif
        .sw_out       (sw1_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] bounce;
        int pulses;
        compared   = 0;
        mismatched = 0;
        bounce     = 5'b10100; // bit e-1 = key level sampled at edge e
        rst    = 1'b1;
        key_n  = 1'b0;
        key1_n = 1'b1;
        sw_in  = 8'hFF;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_key_n_out", 32'(key_n_out), 32'(1));
            check("rst_press", 32'(press_pulse), 32'(0));
            check("rst_release", 32'(release_pulse), 32'(0));
            check("rst_sw_out", 32'(sw_out), 32'(8'h00));
        end
        rst   = 1'b0;
        key_n = 1'b1;
        sw_in = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        check("idle_key_n_out", 32'(key_n_out), 32'(1));

        // Switch path: two-edge latency, no debounce.
        sw_in = 8'hA5;
        tick();
        check("sw_edge1", 32'(sw_out), 32'(8'h00));
        tick();
        check("sw_edge2", 32'(sw_out), 32'(8'hA5));
        sw_in = 8'h3C;
        tick();
        check("sw_hold", 32'(sw_out), 32'(8'hA5));
        tick();
        check("sw_next", 32'(sw_out), 32'(8'h3C));
        check("sw1_next", 32'(sw1_out), 32'(8'h3C));

        // Clean press: pulse after edge 7 only.
        key_n = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("press_pulse", 32'(press_pulse), 32'(e == 7));
            check("press_level", 32'(key_n_out), 32'(e < 7));
            check("press_no_rel", 32'(release_pulse), 32'(0));
        end

        // Clean release.
        key_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("rel_pulse", 32'(release_pulse), 32'(e == 7));
            check("rel_level", 32'(key_n_out), 32'(e >= 7));
            check("rel_no_press", 32'(press_pulse), 32'(0));
        end

        // Bounce: final falling sample at edge 6, single pulse at edge 12.
        pulses = 0;
        for (int e = 1; e <= 25; e++) begin
            key_n = (e <= 5) ? bounce[e-1] : 1'b0;
            tick();
            if (press_pulse) pulses++;
            check("bounce_pulse", 32'(press_pulse), 32'(e == 12));
            check("bounce_level", 32'(key_n_out), 32'(e < 12));
        end
        check("bounce_count", 32'(pulses), 32'(1));
        key_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("bounce_released", 32'(key_n_out), 32'(1));

        // Reset two cycles into PRESS_PEND, then key high: nothing accepted.
        key_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst   = 1'b1;
        key_n = 1'b1;
        tick();
        tick();
        check("midpend_rst_level", 32'(key_n_out), 32'(1));
        rst = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (press_pulse) pulses++;
            check("midpend_level", 32'(key_n_out), 32'(1));
        end
        check("midpend_no_pulse", 32'(pulses), 32'(0));

        // Key held low through reset: full re-qualification afterwards.
        key_n = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("held_pressed", 32'(key_n_out), 32'(0));
        rst = 1'b1;
        tick();
        tick();
        check("held_rst_level", 32'(key_n_out), 32'(1));
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("held_pulse", 32'(press_pulse), 32'(e == 7));
        end
        key_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // DEBOUNCE_CYCLES=1: 4-edge latency both ways.
        key1_n = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("n1_press", 32'(press1_pulse), 32'(e == 4));
            check("n1_level", 32'(key1_n_out), 32'(e < 4));
        end
        key1_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("n1_release", 32'(release1_pulse), 32'(e == 4));
        end

`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
        rst = 1'b1;
        tick();
        check("cnt_rst", 32'(press_count), 32'(0));
        rst = 1'b0;
        tick();
        for (int p = 0; p < 257; p++) begin
            key_n = 1'b0;
            for (int i = 0; i < 10; i++) tick();
            key_n = 1'b1;
            for (int i = 0; i < 10; i++) tick();
        end
        check("cnt_wrap", 32'(press_count), 32'(1));
        rst = 1'b1;
        tick();
        check("cnt_clear", 32'(press_count), 32'(0));
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
